// File: rtl/noc_vc_scheduler_if.sv
// noc_vc_scheduler_if
// Bundles the signals between the per-VC upstream buffers, the scheduler,
// and the physical link.
//   master : upstream/link side. Drives the flits, valids and credit returns.
//            Sees the grants, the link flit and the credit error.
//   slave  : the scheduler.
// Signals:
//   in_flit/in_last/in_valid : per-VC flit offered by the upstream buffer.
//   in_ready                 : one-hot (or zero) grant back to the buffers.
//   out_flit/out_last        : registered link flit and last marker.
//   out_valid                : registered one-hot VC tag; zero means idle.
//   credit_return            : per-VC pulse, one downstream slot freed.
//   credit_err               : registered pulse, a return arrived while full.
interface noc_vc_scheduler_if #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 2
) ();
  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] in_flit;
  logic [CHANNELS-1:0]                 in_last;
  logic [CHANNELS-1:0]                 in_valid;
  logic [CHANNELS-1:0]                 in_ready;
  logic [FLIT_WIDTH-1:0]               out_flit;
  logic                                out_last;
  logic [CHANNELS-1:0]                 out_valid;
  logic [CHANNELS-1:0]                 credit_return;
  logic                                credit_err;

  modport master (
    output in_flit, in_last, in_valid, credit_return,
    input  in_ready, out_flit, out_last, out_valid, credit_err
  );

  modport slave (
    input  in_flit, in_last, in_valid, credit_return,
    output in_ready, out_flit, out_last, out_valid, credit_err
  );
endinterface

// File: rtl/noc_vc_scheduler.sv
// noc_vc_scheduler
// Shares one NoC link among CHANNELS virtual channels, one flit per cycle.
// Each VC keeps a credit counter that mirrors the free slots in the
// downstream VC buffer. A round-robin arbiter grants one eligible VC per
// cycle, which means a VC with valid data and a non-zero credit. The granted
// flit goes out through a single register stage.
// Ports:
//   clk : rising-edge clock.
//   rst : synchronous, active-high reset.
//   bus : noc_vc_scheduler_if.slave. Carries the per-VC flits, valids and
//         grants, the link output, the credit returns and credit_err.
module noc_vc_scheduler #(
  parameter int FLIT_WIDTH   = 32,
  parameter int CHANNELS     = 2,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  noc_vc_scheduler_if.slave     bus
);
  localparam int CRW = $clog2(BUFFER_DEPTH + 1);
  localparam int PW  = $clog2(CHANNELS);
  localparam logic [CRW-1:0] CRED_MAX  = CRW'(BUFFER_DEPTH);
  localparam logic [PW-1:0]  LAST_INIT = PW'(CHANNELS - 1);

  logic [CRW-1:0]        credit_q [CHANNELS];
  logic [CRW-1:0]        credit_d [CHANNELS];
  logic [PW-1:0]         last_q, last_d;
  logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
  logic                  out_last_q, out_last_d;
  logic [CHANNELS-1:0]   out_valid_q, out_valid_d;
  logic                  credit_err_q, credit_err_d;

  logic [CHANNELS-1:0]   eligible;
  logic [CHANNELS-1:0]   grant;
  logic [CHANNELS-1:0]   over_return;
  logic [PW-1:0]         grant_idx;
  logic                  granted;

  // Per-VC eligibility and credit bookkeeping.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_vc
    assign eligible[gi]    = bus.in_valid[gi] && (credit_q[gi] != '0);
    // A return with no matching grant while the counter is already full
    // means the downstream buffer handed back more slots than it has.
    assign over_return[gi] = bus.credit_return[gi] && !grant[gi] &&
                             (credit_q[gi] == CRED_MAX);

    always_comb begin
      credit_d[gi] = credit_q[gi];
      unique case ({bus.credit_return[gi], grant[gi]})
        2'b10:   if (credit_q[gi] != CRED_MAX) credit_d[gi] = credit_q[gi] + 1'b1;
        2'b01:   credit_d[gi] = credit_q[gi] - 1'b1;
        default: credit_d[gi] = credit_q[gi];  // idle, or return and grant cancel out
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) credit_q[gi] <= CRED_MAX;
      else     credit_q[gi] <= credit_d[gi];
    end
  end

  // Round-robin search that starts one past the last granted VC.
  always_comb begin : arb
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = last_q;
    granted   = 1'b0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = (int'(last_q) + i) % CHANNELS;
      if (!granted && eligible[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
        granted    = 1'b1;
      end
    end
  end

  // The grant is masked during reset so that no upstream buffer pops a flit
  // that the reset would drop.
  assign bus.in_ready = rst ? '0 : grant;

  // Link stage next state. With no grant, the data holds and only the tag
  // drops to idle.
  always_comb begin
    out_valid_d  = grant;
    out_flit_d   = out_flit_q;
    out_last_d   = out_last_q;
    last_d       = last_q;
    credit_err_d = |over_return;
    if (granted) begin
      out_flit_d = bus.in_flit[grant_idx];
      out_last_d = bus.in_last[grant_idx];
      last_d     = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_flit_q   <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= '0;
      credit_err_q <= 1'b0;
      last_q       <= LAST_INIT;
    end else begin
      out_flit_q   <= out_flit_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
      credit_err_q <= credit_err_d;
      last_q       <= last_d;
    end
  end

  assign bus.out_flit   = out_flit_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.credit_err = credit_err_q;
endmodule
